// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: default widths, the NOP bubble encoding and
// the IF/ID bundle type seen by decode.
package cpu_pkg;

  localparam int DEF_ADDR_W  = 64;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 16;

  // Bubble encoding. Decode still has to gate on valid, not on this pattern.
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = 32'hD503201F;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_ADDR_W-1:0]  pc_plus4;
    logic [DEF_INSTR_W-1:0] instr;
    logic                   valid;
  } if_id_t;

  // Next value of a counter that sticks at all-ones instead of wrapping.
  function automatic logic [DEF_CNT_W-1:0] satInc(input logic [DEF_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pipe_reg.sv
// Register bank with load enable and synchronous clear to a fixed value.
module pipe_reg
  import cpu_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Clear wins over load; neither means hold.
  always_ff @(posedge clk) begin
    if (clr)     q <= CLR_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/sat_counter.sv
// Unsigned event counter that saturates at all-ones.
module sat_counter
  import cpu_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count up on inc, stop at the maximum so debug reads never wrap to small values.
  always_ff @(posedge clk) begin
    if (clr)                    cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID boundary: registers fetched PC, PC+4 and instruction for decode, with
// hazard stall (hold), branch flush (NOP bubble) and saturating debug counters.
module if_id_pipe_reg
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = DEF_ADDR_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 CNT_W     = DEF_CNT_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  if_pc,
  input  logic [ADDR_W-1:0]  if_pc_plus4,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               if_valid,
  input  logic               stall,
  input  logic               flush,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus4,
  output logic [INSTR_W-1:0] id_instr,
  output logic               id_valid,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  // Priority rst > flush > stall > load. Both rst and flush clear the stage,
  // so the banks only need one clear and one load enable.
  logic clrStage, loadStage, stallInc, flushInc;
  logic [INSTR_W-1:0] nextInstr;

  assign clrStage  = rst | flush;
  assign loadStage = ~stall;
  assign stallInc  = ~rst & ~flush & stall;
  // Only count flushes that actually squash an instruction.
  assign flushInc  = ~rst & flush & (id_valid | if_valid);
  // An invalid fetch still loads its PC fields but presents a bubble encoding.
  assign nextInstr = if_valid ? if_instr : NOP_INSTR;

  pipe_reg #(.WIDTH(ADDR_W), .CLR_VAL('0)) uPc (
    .clk(clk), .clr(clrStage), .en(loadStage), .d(if_pc), .q(id_pc)
  );

  pipe_reg #(.WIDTH(ADDR_W), .CLR_VAL('0)) uPcPlus4 (
    .clk(clk), .clr(clrStage), .en(loadStage), .d(if_pc_plus4), .q(id_pc_plus4)
  );

  pipe_reg #(.WIDTH(INSTR_W), .CLR_VAL(NOP_INSTR)) uInstr (
    .clk(clk), .clr(clrStage), .en(loadStage), .d(nextInstr), .q(id_instr)
  );

  pipe_reg #(.WIDTH(1), .CLR_VAL(1'b0)) uValid (
    .clk(clk), .clr(clrStage), .en(loadStage), .d(if_valid), .q(id_valid)
  );

  sat_counter #(.CNT_W(CNT_W)) uStallCnt (
    .clk(clk), .clr(rst), .inc(stallInc), .cnt(stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) uFlushCnt (
    .clk(clk), .clr(rst), .inc(flushInc), .cnt(flush_cnt)
  );

endmodule
